// File: rtl/ascon_ctrl_fsm_pkg.sv
// Shared state type and round constants for the ASCON-128 control sequencer.
package ascon_pack;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_AD,
    AD,
    WAIT_PT,
    PT,
    FINAL,
    DONE
  } type_ctrl_state;

  localparam logic [3:0] ROUND_P12_START = 4'd0;
  localparam logic [3:0] ROUND_P6_START  = 4'd6;
  localparam logic [3:0] ROUND_LAST      = 4'd11;

endpackage

// File: rtl/ascon_ctrl_fsm_round_counter.sv
// Loadable round counter for the permutation; flags the final round 11.
module round_counter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic [3:0] round_o,
  output logic       last_o
);

  logic [3:0] round_q;

  // Load has priority so a phase boundary can wrap straight to the next start round.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      round_q <= ROUND_P12_START;
    end else if (load_i) begin
      round_q <= load_val_i;
    end else if (en_i) begin
      round_q <= round_q + 4'd1;
    end else begin
      round_q <= round_q;
    end
  end

  assign round_o = round_q;
  assign last_o  = (round_q == ROUND_LAST);

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 sequencer: init p12, one AD block p6, NB_BLOCKS PT blocks, final p12.
// Optional macro ASCON_CTRL_ABORT_EN adds abort_i, which returns any busy state to IDLE.
module ascon_ctrl_fsm
  import ascon_pack::*;
#(
  parameter int NB_BLOCKS = 4,
  localparam int IDXW = $clog2(NB_BLOCKS + 1)
) (
  input  logic            clock_i,
  input  logic            reset_i,
`ifdef ASCON_CTRL_ABORT_EN
  input  logic            abort_i,
`endif
  input  logic            start_i,
  input  logic            data_valid_i,
  output logic            data_ready_o,
  output logic [3:0]      round_o,
  output logic            data_sel_o,
  output logic            en_reg_state_o,
  output logic            en_xor_data_o,
  output logic            en_xor_key_o,
  output logic            en_xor_key_end_o,
  output logic            en_xor_lsb_o,
  output logic            en_cipher_o,
  output logic            en_tag_o,
  output logic            cipher_valid_o,
  output logic [IDXW-1:0] block_idx_o,
  output logic            busy_o,
  output logic            done_o
);

  type_ctrl_state  state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            cipher_valid_q;
  logic            cnt_load_s, cnt_en_s, cnt_last_s, abort_s, xfer_s;
  logic [3:0]      cnt_val_s, cnt_round_s;

`ifdef ASCON_CTRL_ABORT_EN
  assign abort_s = abort_i & (state_q != IDLE);
`else
  assign abort_s = 1'b0;
`endif

  // An abort in the same cycle as a transfer cancels the transfer.
  assign xfer_s = data_valid_i & ~abort_s;

  round_counter u_round_counter (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_val_s),
    .en_i       (cnt_en_s),
    .round_o    (cnt_round_s),
    .last_o     (cnt_last_s)
  );

  // Next-state, counter control and output decode; WAIT states are Mealy on xfer_s.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    cnt_load_s       = 1'b0;
    cnt_val_s        = ROUND_P12_START;
    cnt_en_s         = 1'b0;
    round_o          = cnt_round_s;
    data_ready_o     = 1'b0;
    data_sel_o       = 1'b0;
    en_reg_state_o   = 1'b0;
    en_xor_data_o    = 1'b0;
    en_xor_key_o     = 1'b0;
    en_xor_key_end_o = 1'b0;
    en_xor_lsb_o     = 1'b0;
    en_cipher_o      = 1'b0;
    en_tag_o         = 1'b0;
    done_o           = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        done_o = (state_q == DONE);
        if (start_i) begin
          state_d    = INIT;
          idx_d      = '0;
          cnt_load_s = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      INIT, AD, PT, FINAL: begin
        en_reg_state_o = 1'b1;
        data_sel_o     = (state_q == INIT) && (cnt_round_s == ROUND_P12_START);
        if (cnt_last_s) begin
          cnt_load_s       = 1'b1;
          cnt_val_s        = ROUND_P6_START;
          en_xor_key_end_o = (state_q == INIT);
          en_xor_lsb_o     = (state_q == AD);
          en_tag_o         = (state_q == FINAL);
          if (state_q == INIT) begin
            state_d = WAIT_AD;
          end else if (state_q == FINAL) begin
            state_d   = DONE;
            idx_d     = '0;
            cnt_val_s = ROUND_P12_START;
          end else begin
            state_d = WAIT_PT;
            idx_d   = (state_q == PT) ? idx_q + IDXW'(1) : idx_q;
          end
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      WAIT_AD, WAIT_PT: begin
        data_ready_o = 1'b1;
        if (xfer_s) begin
          en_reg_state_o = 1'b1;
          en_xor_data_o  = 1'b1;
          en_cipher_o    = (state_q == WAIT_PT);
          if (state_q == WAIT_AD) begin
            state_d  = AD;
            cnt_en_s = 1'b1;
          end else if (idx_q == IDXW'(NB_BLOCKS - 1)) begin
            // Last plaintext block is absorbed as round 0 of finalization.
            state_d      = FINAL;
            round_o      = ROUND_P12_START;
            en_xor_key_o = 1'b1;
            cnt_load_s   = 1'b1;
            cnt_val_s    = ROUND_P12_START + 4'd1;
          end else begin
            state_d  = PT;
            cnt_en_s = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d    = IDLE;
        idx_d      = '0;
        cnt_load_s = 1'b1;
      end
    endcase
    if (abort_s) begin
      state_d    = IDLE;
      idx_d      = '0;
      cnt_load_s = 1'b1;
      cnt_val_s  = ROUND_P12_START;
    end else begin
      state_d = state_d;
    end
  end

  // State, block index and cipher-valid strobe registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      cipher_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cipher_valid_q <= en_cipher_o;
    end
  end

  assign cipher_valid_o = cipher_valid_q;
  assign block_idx_o    = idx_q;
  assign busy_o         = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: NB_BLOCKS=4 and NB_BLOCKS=1 instances against a phase-list model.
module tb_ascon_ctrl_fsm;

  typedef struct packed {
    logic       ready;
    logic [3:0] round;
    logic       sel, reg_en, xd, xk, xke, lsb, ciph, tag, cv, busy, done;
    logic [2:0] idx;
  } outs_t;

  typedef struct {
    int    cyc;
    string name;
    outs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1, start_i = 1'b0, data_valid_i = 1'b0, abort_i = 1'b0;
  logic [1:0] rdy, sel, rg, xd, xk, xke, lsb, ci, tg, cv, bz, dn;
  logic [3:0] rnd [2];
  logic [2:0] idx4;
  logic [0:0] idx1;
  outs_t o [2];

  int total = 0, bad = 0;
  int mm [2], mph [2], mpos [2];
  bit mwait [2], mpc [2];
  int nbv [2] = '{4, 1};
  bit track1 = 1'b0;
  int cnt1 = 0;
  vec_t tbl [15];

  always #5 clk = ~clk;

  ascon_ctrl_fsm #(.NB_BLOCKS(4)) u4 (
    .clock_i(clk), .reset_i(reset_i),
`ifdef ASCON_CTRL_ABORT_EN
    .abort_i(abort_i),
`endif
    .start_i(start_i), .data_valid_i(data_valid_i), .data_ready_o(rdy[0]),
    .round_o(rnd[0]), .data_sel_o(sel[0]), .en_reg_state_o(rg[0]), .en_xor_data_o(xd[0]),
    .en_xor_key_o(xk[0]), .en_xor_key_end_o(xke[0]), .en_xor_lsb_o(lsb[0]),
    .en_cipher_o(ci[0]), .en_tag_o(tg[0]), .cipher_valid_o(cv[0]), .block_idx_o(idx4),
    .busy_o(bz[0]), .done_o(dn[0])
  );

  ascon_ctrl_fsm #(.NB_BLOCKS(1)) u1 (
    .clock_i(clk), .reset_i(reset_i),
`ifdef ASCON_CTRL_ABORT_EN
    .abort_i(abort_i),
`endif
    .start_i(start_i), .data_valid_i(data_valid_i), .data_ready_o(rdy[1]),
    .round_o(rnd[1]), .data_sel_o(sel[1]), .en_reg_state_o(rg[1]), .en_xor_data_o(xd[1]),
    .en_xor_key_o(xk[1]), .en_xor_key_end_o(xke[1]), .en_xor_lsb_o(lsb[1]),
    .en_cipher_o(ci[1]), .en_tag_o(tg[1]), .cipher_valid_o(cv[1]), .block_idx_o(idx1),
    .busy_o(bz[1]), .done_o(dn[1])
  );

  assign o[0] = {rdy[0], rnd[0], sel[0], rg[0], xd[0], xk[0], xke[0], lsb[0], ci[0], tg[0],
                 cv[0], bz[0], dn[0], idx4};
  assign o[1] = {rdy[1], rnd[1], sel[1], rg[1], xd[1], xk[1], xke[1], lsb[1], ci[1], tg[1],
                 cv[1], bz[1], dn[1], 2'b00, idx1};

  function automatic outs_t mk(bit r, int n, bit s, bit g, bit x, bit k, bit ke, bit l,
                               bit c, bit t, bit v, bit b, bit d, int i);
    mk = {r, 4'(n), s, g, x, k, ke, l, c, t, v, b, d, 3'(i)};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Phase list: phase 0 = init p12, phase a+1 = wait then absorb block a
  // (a=0 AD, a=1..NB-1 plaintext, a=NB last plaintext merged into final p12).
  function automatic outs_t model_out(int d, bit dv);
    outs_t r = '0;
    int a = mph[d] - 1;
    int base;
    r.cv = mpc[d];
    if (mm[d] == 2) r.done = 1'b1;
    else if (mm[d] == 1) begin
      r.busy = 1'b1;
      if (mph[d] == 0) begin
        r.round = 4'(mpos[d]); r.reg_en = 1'b1;
        r.sel = (mpos[d] == 0); r.xke = (mpos[d] == 11);
      end else begin
        r.idx = (a >= 1) ? 3'(a - 1) : 3'd0;
        if (mwait[d]) begin
          r.ready = 1'b1; r.round = 4'd6;
          if (dv) begin
            r.reg_en = 1'b1; r.xd = 1'b1; r.ciph = (a >= 1); r.xk = (a == nbv[d]);
            if (a == nbv[d]) r.round = 4'd0;
          end
        end else begin
          base = (a == nbv[d]) ? 0 : 6;
          r.round = 4'(base + mpos[d]); r.reg_en = 1'b1;
          r.lsb = (a == 0) && (base + mpos[d] == 11);
          r.tag = (a == nbv[d]) && (base + mpos[d] == 11);
        end
      end
    end
    return r;
  endfunction

  task automatic model_step(int d, bit st, bit dv, bit rs, bit ab);
    outs_t r = model_out(d, dv);
    int a = mph[d] - 1;
    if (rs || (ab && mm[d] != 0)) begin
      mm[d] = 0; mpc[d] = 1'b0;
    end else begin
      mpc[d] = r.ciph;
      if (mm[d] != 1) begin
        if (st) begin mm[d] = 1; mph[d] = 0; mpos[d] = 0; mwait[d] = 1'b0; end
      end else if (mph[d] == 0) begin
        mpos[d]++;
        if (mpos[d] == 12) begin mph[d] = 1; mwait[d] = 1'b1; end
      end else if (mwait[d]) begin
        if (dv) begin mwait[d] = 1'b0; mpos[d] = 1; end
      end else begin
        mpos[d]++;
        if (mpos[d] == ((a == nbv[d]) ? 12 : 6)) begin
          if (a == nbv[d]) mm[d] = 2;
          else begin mph[d]++; mwait[d] = 1'b1; end
        end
      end
    end
  endtask

  task automatic apply(bit st, bit dv, bit rs, bit ab, bit c);
    start_i = st; data_valid_i = dv; reset_i = rs; abort_i = ab;
    #1;
    for (int d = 0; d < 2; d++)
      if (c) chk($sformatf("model_nb%0d", nbv[d]), 32'(o[d]), 32'(model_out(d, dv)));
    if (track1 && ci[1]) begin
      cnt1++;
      chk("nb1_cipher_with_key_r0", {27'd0, xk[1], rnd[1]}, {27'd0, 1'b1, 4'd0});
    end
  endtask

  task automatic step();
    for (int d = 0; d < 2; d++) model_step(d, start_i, data_valid_i, reset_i, abort_i);
    @(negedge clk);
  endtask

  initial begin
    int ti;
    tbl[0]  = '{0,  "idle_start", mk(0, 0, 0,0,0,0,0,0,0,0,0,0,0, 0)};
    tbl[1]  = '{1,  "init_r0",    mk(0, 0, 1,1,0,0,0,0,0,0,0,1,0, 0)};
    tbl[2]  = '{2,  "init_r1",    mk(0, 1, 0,1,0,0,0,0,0,0,0,1,0, 0)};
    tbl[3]  = '{12, "init_r11",   mk(0, 11,0,1,0,0,1,0,0,0,0,1,0, 0)};
    tbl[4]  = '{13, "ad_xfer",    mk(1, 6, 0,1,1,0,0,0,0,0,0,1,0, 0)};
    tbl[5]  = '{14, "ad_r7",      mk(0, 7, 0,1,0,0,0,0,0,0,0,1,0, 0)};
    tbl[6]  = '{18, "ad_r11",     mk(0, 11,0,1,0,0,0,1,0,0,0,1,0, 0)};
    tbl[7]  = '{19, "pt0_xfer",   mk(1, 6, 0,1,1,0,0,0,1,0,0,1,0, 0)};
    tbl[8]  = '{20, "pt0_r7",     mk(0, 7, 0,1,0,0,0,0,0,0,1,1,0, 0)};
    tbl[9]  = '{25, "pt1_xfer",   mk(1, 6, 0,1,1,0,0,0,1,0,0,1,0, 1)};
    tbl[10] = '{37, "last_xfer",  mk(1, 0, 0,1,1,1,0,0,1,0,0,1,0, 3)};
    tbl[11] = '{38, "final_r1",   mk(0, 1, 0,1,0,0,0,0,0,0,1,1,0, 3)};
    tbl[12] = '{48, "final_r11",  mk(0, 11,0,1,0,0,0,0,0,1,0,1,0, 3)};
    tbl[13] = '{49, "done",       mk(0, 0, 0,0,0,0,0,0,0,0,0,0,1, 0)};
    tbl[14] = '{50, "done_hold",  mk(0, 0, 0,0,0,0,0,0,0,0,0,0,1, 0)};
    for (int d = 0; d < 2; d++) begin
      mm[d] = 0; mph[d] = 0; mpos[d] = 0; mwait[d] = 1'b0; mpc[d] = 1'b0;
    end

    @(negedge clk);
    apply(0, 0, 1, 0, 0); step();
    apply(0, 0, 1, 0, 0); step();
    apply(0, 0, 0, 0, 1);
    chk("reset_state_nb4", 32'(o[0]), 32'd0);
    chk("reset_state_nb1", 32'(o[1]), 32'd0);
    step();

    // Full message with data always valid, checked against fixed timeline.
    ti = 0; track1 = 1'b1;
    for (int c = 0; c <= 50; c++) begin
      apply(c == 0, 1, 0, 0, 1);
      if (ti < 15 && tbl[ti].cyc == c) begin
        chk(tbl[ti].name, 32'(o[0]), 32'(tbl[ti].exp));
        ti++;
      end
      step();
    end
    track1 = 1'b0;
    chk("nb1_cipher_count", 32'(cnt1), 32'd1);

    // Reset asserted for 2 cycles mid-INIT.
    apply(1, 1, 0, 0, 1); step();
    for (int c = 0; c < 5; c++) begin apply(0, 1, 0, 0, 1); step(); end
    apply(0, 1, 1, 0, 1); step();
    apply(0, 1, 1, 0, 1); step();
    apply(0, 0, 0, 0, 1);
    chk("reset_mid_init", 32'(o[0]), 32'd0);
    step();

    // Host stalls 5 cycles in WAIT_PT.
    for (int c = 0; c < 40; c++) begin
      apply(c == 0, !(c >= 19 && c <= 23), 0, 0, 1);
      if (c >= 19 && c <= 23)
        chk("wait_pt_hold", {26'd0, rdy[0], rg[0], rnd[0]}, {26'd0, 1'b1, 1'b0, 4'd6});
      step();
    end

`ifdef ASCON_CTRL_ABORT_EN
    apply(0, 0, 1, 0, 1); step();
    for (int c = 0; c < 60; c++) begin
      apply(c == 0, 1, 0, c == 15, 1);
      if (c == 15) chk("abort_in_ad_r8", 32'(rnd[0]), 32'd8);
      if (c == 16) chk("abort_idle", 32'(o[0]), 32'd0);
      if (c > 16) chk("abort_no_done", 32'(dn), 32'd0);
      step();
    end
`endif

    // Randomised host behaviour, including back-to-back starts and rare resets.
    for (int c = 0; c < 3000; c++) begin
      apply($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 499) == 0, 0, 1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
